// File: rtl/ahblite_busmatrix_pkg.sv
// Shared constants and types for the AHB-Lite bus matrix blocks.
package ahblite_busmatrix_pkg;

  localparam int DEFAULT_ADDR_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Control fields carried with the address: HTRANS, HWRITE, HSIZE, HBURST, HPROT
  localparam int CTRL_W = 13;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } inputstage_state_e;

  // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY carry no transfer.
  function automatic logic is_active_trans(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahblite_busmatrix_inputstage_if.sv
// Master-port and decoder-side signals of one bus matrix input stage.
interface ahblite_busmatrix_inputstage_if
  import ahblite_busmatrix_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
);
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [3:0]        HPROT;
  logic              HREADY;
  logic              HREADYOUT;
  logic              HRESP;

  logic              HSEL_o;
  logic [ADDR_W-1:0] HADDR_o;
  logic [1:0]        HTRANS_o;
  logic              HWRITE_o;
  logic [2:0]        HSIZE_o;
  logic [2:0]        HBURST_o;
  logic [3:0]        HPROT_o;
  logic              TRANS_HOLD;

  logic              ACTIVE_Decoder;
  logic              HREADYOUT_Decoder;
  logic              HRESP_Decoder;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HREADY,
    output HREADYOUT, HRESP,
    output HSEL_o, HADDR_o, HTRANS_o, HWRITE_o, HSIZE_o, HBURST_o, HPROT_o, TRANS_HOLD,
    input  ACTIVE_Decoder, HREADYOUT_Decoder, HRESP_Decoder
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HREADY,
    input  HREADYOUT, HRESP,
    input  HSEL_o, HADDR_o, HTRANS_o, HWRITE_o, HSIZE_o, HBURST_o, HPROT_o, TRANS_HOLD,
    output ACTIVE_Decoder, HREADYOUT_Decoder, HRESP_Decoder
  );

endinterface

// File: rtl/ahblite_addr_hold_reg.sv
// Load-enabled capture register for a stalled master's address-phase bundle.
module ahblite_addr_hold_reg #(
  parameter int WIDTH = 45
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] hold_r;

  // Capture register: written only when a transfer has to be parked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r <= {WIDTH{1'b0}};
    end else if (load) begin
      hold_r <= d;
    end else begin
      hold_r <= hold_r;
    end
  end

  assign q = hold_r;

endmodule

// File: rtl/ahblite_busmatrix_inputstage.sv
// Bus matrix input stage: parks an ungranted address phase, stalls the master,
// replays it once the output stage routes it, and returns the slave's response.
module ahblite_busmatrix_inputstage
  import ahblite_busmatrix_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input logic                          HCLK,
  input logic                          HRESETn,
  ahblite_busmatrix_inputstage_if.slave bus
);

  localparam int HOLD_W = ADDR_W + CTRL_W;

  inputstage_state_e state_r;
  inputstage_state_e state_next_s;
  logic              data_phase_r;
  logic              data_phase_next_s;
  logic              new_trans_s;
  logic              accept_s;
  logic              taken_s;
  logic              capture_s;
  logic              pend_s;

  logic [HOLD_W-1:0] live_bundle_s;
  logic [HOLD_W-1:0] hold_bundle_s;
  logic [ADDR_W-1:0] hold_haddr_s;
  logic [1:0]        hold_htrans_s;
  logic              hold_hwrite_s;
  logic [2:0]        hold_hsize_s;
  logic [2:0]        hold_hburst_s;
  logic [3:0]        hold_hprot_s;

  assign new_trans_s = bus.HSEL & is_active_trans(bus.HTRANS) & bus.HREADY;
  assign accept_s    = bus.ACTIVE_Decoder & bus.HREADYOUT_Decoder;
  assign pend_s      = (state_r == ST_PEND);

  assign live_bundle_s = {bus.HADDR, bus.HTRANS, bus.HWRITE, bus.HSIZE, bus.HBURST, bus.HPROT};
  assign {hold_haddr_s, hold_htrans_s, hold_hwrite_s,
          hold_hsize_s, hold_hburst_s, hold_hprot_s} = hold_bundle_s;

  ahblite_addr_hold_reg #(
    .WIDTH (HOLD_W)
  ) u_hold (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .load  (capture_s),
    .d     (live_bundle_s),
    .q     (hold_bundle_s)
  );

  // State and data-phase registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r      <= ST_IDLE;
      data_phase_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      data_phase_r <= data_phase_next_s;
    end
  end

  // Next state, capture strobe and data-phase tracking.
  always_comb begin
    state_next_s      = state_r;
    capture_s         = 1'b0;
    taken_s           = 1'b0;
    data_phase_next_s = data_phase_r;
    case (state_r)
      ST_IDLE: begin
        if (new_trans_s && !accept_s) begin
          state_next_s = ST_PEND;
          capture_s    = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
          taken_s      = new_trans_s;
        end
      end
      ST_PEND: begin
        // A master that violates HREADY here is ignored; the hold stays frozen.
        if (accept_s) begin
          state_next_s = ST_IDLE;
          taken_s      = 1'b1;
        end else begin
          state_next_s = ST_PEND;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
    if (taken_s) begin
      data_phase_next_s = 1'b1;
    end else if (bus.HREADYOUT_Decoder) begin
      data_phase_next_s = 1'b0;
    end else begin
      data_phase_next_s = data_phase_r;
    end
  end

  // Address-phase mux towards the decoder plus master-facing ready/response.
  always_comb begin
    if (pend_s) begin
      bus.HSEL_o   = 1'b1;
      bus.HADDR_o  = hold_haddr_s;
      bus.HTRANS_o = hold_htrans_s;
      bus.HWRITE_o = hold_hwrite_s;
      bus.HSIZE_o  = hold_hsize_s;
      bus.HBURST_o = hold_hburst_s;
      bus.HPROT_o  = hold_hprot_s;
    end else begin
      bus.HSEL_o   = bus.HSEL;
      bus.HADDR_o  = bus.HADDR;
      bus.HTRANS_o = bus.HSEL ? bus.HTRANS : HTRANS_IDLE;
      bus.HWRITE_o = bus.HWRITE;
      bus.HSIZE_o  = bus.HSIZE;
      bus.HBURST_o = bus.HBURST;
      bus.HPROT_o  = bus.HPROT;
    end

    bus.TRANS_HOLD = pend_s | (bus.HSEL & is_active_trans(bus.HTRANS));

    if (pend_s) begin
      bus.HREADYOUT = 1'b0;
    end else if (data_phase_r) begin
      bus.HREADYOUT = bus.HREADYOUT_Decoder;
    end else begin
      bus.HREADYOUT = 1'b1;
    end

    if (data_phase_r) begin
      bus.HRESP = bus.HRESP_Decoder;
    end else begin
      bus.HRESP = HRESP_OKAY;
    end
  end

endmodule
